// File: rtl/cmi_pkg.sv
// Shared types and code constants for the CMI receive path.
package cmi_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StCheck,
    StLock
  } state_e;

  localparam logic [1:0] CMI_ZERO = 2'b01;
  localparam logic [1:0] CMI_BAD  = 2'b10;

endpackage

// File: rtl/cmi_pair_check.sv
// Combinational CMI code-rule check for one received code pair.
module cmi_pair_check
  import cmi_pkg::*;
(
  input  logic [1:0] pair_i,
  input  logic       last_mark_i,
  input  logic       mark_known_i,
  output logic       viol_o,
  output logic       is_mark_o,
  output logic       data_bit_o
);

  assign is_mark_o = (pair_i[1] == pair_i[0]);

  // A mark must alternate polarity with the previous valid mark once one is known.
  assign viol_o = (pair_i == CMI_BAD) |
                  (is_mark_o & mark_known_i & (pair_i[1] == last_mark_i));

  assign data_bit_o = (pair_i != CMI_ZERO) && (pair_i != CMI_BAD);

endmodule

// File: rtl/cmi_align_dec.sv
// CMI receiver: finds pair boundaries, checks code rules, declares lock and counts
// violations seen while locked.
module cmi_align_dec
  import cmi_pkg::*;
#(
  parameter int unsigned LOCK_N    = 16,
  parameter int unsigned WIN       = 32,
  parameter int unsigned UNLOCK_TH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             serial_sig,
  output logic [1:0]       pair_sig,
  output logic             pair_valid,
  output logic             decode_sig,
  output logic             decode_valid,
  output logic             lock_sig,
  output logic             viol_sig,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned GoodW = $clog2(LOCK_N + 1);
  localparam int unsigned WinW  = $clog2(WIN + 1);
  localparam int unsigned ErrW  = $clog2(UNLOCK_TH + 1);

  localparam logic [GoodW-1:0] LockNVal  = GoodW'(LOCK_N);
  localparam logic [WinW-1:0]  WinVal    = WinW'(WIN);
  localparam logic [ErrW-1:0]  UnlockVal = ErrW'(UNLOCK_TH);

  state_e           state_q;
  logic             sr_q;
  logic             phase_q;
  logic             mark_known_q;
  logic             last_mark_q;
  logic [GoodW-1:0] good_cnt_q;
  logic [WinW-1:0]  win_cnt_q;
  logic [ErrW-1:0]  win_err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [1:0]       pair_q;
  logic             pair_valid_q;
  logic             decode_q;
  logic             decode_valid_q;
  logic             viol_q;

  logic [1:0]       pair;
  logic             viol;
  logic             is_mark;
  logic             data_bit;
  logic [GoodW-1:0] good_inc;
  logic [WinW-1:0]  win_inc;
  logic [ErrW-1:0]  win_err_nxt;

  assign pair        = {sr_q, serial_sig};
  assign good_inc    = good_cnt_q + GoodW'(1);
  assign win_inc     = win_cnt_q + WinW'(1);
  assign win_err_nxt = viol ? (win_err_q + ErrW'(1)) : win_err_q;

  cmi_pair_check u_pair_check (
    .pair_i       (pair),
    .last_mark_i  (last_mark_q),
    .mark_known_i (mark_known_q),
    .viol_o       (viol),
    .is_mark_o    (is_mark),
    .data_bit_o   (data_bit)
  );

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q        <= StHunt;
      sr_q           <= 1'b0;
      phase_q        <= 1'b0;
      mark_known_q   <= 1'b0;
      last_mark_q    <= 1'b0;
      good_cnt_q     <= '0;
      win_cnt_q      <= '0;
      win_err_q      <= '0;
      err_cnt_q      <= '0;
      pair_q         <= '0;
      pair_valid_q   <= 1'b0;
      decode_q       <= 1'b0;
      decode_valid_q <= 1'b0;
      viol_q         <= 1'b0;
    end else begin
      sr_q           <= serial_sig;
      phase_q        <= ~phase_q;
      pair_valid_q   <= 1'b0;
      decode_valid_q <= 1'b0;
      viol_q         <= 1'b0;
      if (phase_q) begin
        pair_q       <= pair;
        pair_valid_q <= 1'b1;
        decode_q     <= data_bit;
        viol_q       <= viol;
        if (is_mark && !viol) begin
          last_mark_q  <= pair[1];
          mark_known_q <= 1'b1;
        end
        unique case (state_q)
          StHunt: begin
            if (viol) begin
              // Slip: keep phase high so the next bit closes a pair shifted by one.
              phase_q      <= 1'b1;
              mark_known_q <= 1'b0;
            end else begin
              state_q    <= StCheck;
              good_cnt_q <= GoodW'(1);
            end
          end
          StCheck: begin
            if (viol) begin
              phase_q      <= 1'b1;
              mark_known_q <= 1'b0;
              state_q      <= StHunt;
              good_cnt_q   <= '0;
            end else begin
              good_cnt_q <= good_inc;
              if (good_inc == LockNVal) begin
                state_q        <= StLock;
                win_cnt_q      <= '0;
                win_err_q      <= '0;
                decode_valid_q <= 1'b1;
              end
            end
          end
          StLock: begin
            decode_valid_q <= 1'b1;
            win_cnt_q      <= win_inc;
            win_err_q      <= win_err_nxt;
            if (viol && (err_cnt_q != {CNT_W{1'b1}})) begin
              err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            // Unlock takes priority over a window roll on the same pair.
            if (win_err_nxt == UnlockVal) begin
              state_q        <= StHunt;
              mark_known_q   <= 1'b0;
              good_cnt_q     <= '0;
              decode_valid_q <= 1'b0;
            end else if (win_inc == WinVal) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  assign pair_sig     = pair_q;
  assign pair_valid   = pair_valid_q;
  assign decode_sig   = decode_q;
  assign decode_valid = decode_valid_q;
  assign lock_sig     = (state_q == StLock);
  assign viol_sig     = viol_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_cmi_align_dec.sv
// Directed and randomized bench for cmi_align_dec against a pair-level reference model.
module tb_cmi_align_dec;

  localparam int LockN = 16;
  localparam int Win   = 32;
  localparam int Th    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ser = 1'b0;

  logic [1:0]  pair_sig;
  logic        pair_valid, decode_sig, decode_valid, lock_sig, viol_sig;
  logic [15:0] err_cnt;

  logic [1:0]  s_pair_sig;
  logic        s_pair_valid, s_decode_sig, s_decode_valid, s_lock_sig, s_viol_sig;
  logic [1:0]  s_err_cnt;

  cmi_align_dec dut (
    .clk_sig      (clk),
    .reset_sig    (rst),
    .serial_sig   (ser),
    .pair_sig     (pair_sig),
    .pair_valid   (pair_valid),
    .decode_sig   (decode_sig),
    .decode_valid (decode_valid),
    .lock_sig     (lock_sig),
    .viol_sig     (viol_sig),
    .err_cnt      (err_cnt)
  );

  cmi_align_dec #(.CNT_W(2)) dut_sat (
    .clk_sig      (clk),
    .reset_sig    (rst),
    .serial_sig   (ser),
    .pair_sig     (s_pair_sig),
    .pair_valid   (s_pair_valid),
    .decode_sig   (s_decode_sig),
    .decode_valid (s_decode_valid),
    .lock_sig     (s_lock_sig),
    .viol_sig     (s_viol_sig),
    .err_cnt      (s_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 hunting, 1 checking, 2 locked
  int       m_state;
  bit       m_have_first, m_first, m_known, m_last;
  int       m_good, m_wcnt, m_werr, m_errs;
  bit       e_pv, e_dv, e_viol, e_dec;
  bit [1:0] e_pair;
  bit       gen_pol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_have_first = 0; m_first = 0; m_known = 0; m_last = 0;
    m_good = 0; m_wcnt = 0; m_werr = 0; m_errs = 0;
    e_pv = 0; e_dv = 0; e_viol = 0; e_dec = 0; e_pair = 2'b00;
    gen_pol = 0;
  endtask

  task automatic model_bit(input bit b);
    bit [1:0] p;
    bit mark, bad;
    e_pv = 0; e_dv = 0; e_viol = 0;
    if (!m_have_first) begin
      m_have_first = 1;
      m_first = b;
      return;
    end
    p = {m_first, b};
    m_have_first = 0;
    mark = (m_first == b);
    bad = (p == 2'b10) || (mark && m_known && (m_first == m_last));
    if (mark && !bad) begin
      m_last = m_first;
      m_known = 1;
    end
    e_pv = 1; e_pair = p; e_dec = mark; e_viol = bad;
    case (m_state)
      0: begin
        if (bad) begin
          m_have_first = 1; m_first = b; m_known = 0;
        end else begin
          m_state = 1; m_good = 1;
        end
      end
      1: begin
        if (bad) begin
          m_have_first = 1; m_first = b; m_known = 0;
          m_state = 0; m_good = 0;
        end else begin
          m_good++;
          if (m_good == LockN) begin
            m_state = 2; m_wcnt = 0; m_werr = 0;
          end
        end
      end
      default: begin
        m_wcnt++;
        if (bad) begin
          m_werr++;
          m_errs++;
        end
        if (m_werr == Th) begin
          m_state = 0; m_known = 0; m_good = 0;
        end else if (m_wcnt == Win) begin
          m_wcnt = 0; m_werr = 0;
        end
      end
    endcase
    e_dv = (m_state == 2);
  endtask

  task automatic check_outputs();
    chk("pair_valid", 32'(pair_valid), 32'(e_pv));
    chk("pair_sig", 32'(pair_sig), 32'(e_pair));
    chk("decode_sig", 32'(decode_sig), 32'(e_dec));
    chk("decode_valid", 32'(decode_valid), 32'(e_dv));
    chk("lock_sig", 32'(lock_sig), 32'(m_state == 2));
    chk("viol_sig", 32'(viol_sig), 32'(e_viol));
    chk("err_cnt", 32'(err_cnt), (m_errs > 65535) ? 32'd65535 : 32'(m_errs));
    chk("sat_viol_sig", 32'(s_viol_sig), 32'(e_viol));
    chk("sat_err_cnt", 32'(s_err_cnt), (m_errs > 3) ? 32'd3 : 32'(m_errs));
  endtask

  task automatic drive_bit(input bit b);
    ser = b;
    @(posedge clk);
    #1;
    model_bit(b);
    check_outputs();
  endtask

  task automatic send_pair(input bit a, input bit b);
    drive_bit(a);
    drive_bit(b);
  endtask

  task automatic send_data(input bit d);
    if (!d) begin
      send_pair(1'b0, 1'b1);
    end else begin
      send_pair(gen_pol, gen_pol);
      gen_pol = ~gen_pol;
    end
  endtask

  // Repeats the polarity of the last mark sent.
  task automatic send_badmark();
    send_pair(~gen_pol, ~gen_pol);
  endtask

  task automatic send_pattern(input int pairs);
    for (int i = 0; i < pairs; i++) send_data(1'(i % 2));
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_pair_valid", 32'(pair_valid), 32'd0);
    chk("rst_pair_sig", 32'(pair_sig), 32'd0);
    chk("rst_decode_sig", 32'(decode_sig), 32'd0);
    chk("rst_decode_valid", 32'(decode_valid), 32'd0);
    chk("rst_lock_sig", 32'(lock_sig), 32'd0);
    chk("rst_viol_sig", 32'(viol_sig), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_sat_err_cnt", 32'(s_err_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int r;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // T2: aligned stream locks on the 16th pair
    send_pattern(15);
    chk("t2_not_yet_locked", 32'(lock_sig), 32'd0);
    send_data(1'b1);
    chk("t2_lock_16th", 32'(lock_sig), 32'd1);
    chk("t2_dv_16th", 32'(decode_valid), 32'd1);
    send_pattern(4);

    // T4: four repeated-polarity marks inside one window force unlock
    for (int i = 0; i < 4; i++) begin
      send_badmark();
      if (i < 3) send_data(1'b0);
    end
    chk("t4_unlock", 32'(lock_sig), 32'd0);
    chk("t4_err_cnt", 32'(err_cnt), 32'd4);

    // T1: asynchronous reset mid-operation
    do_reset();

    // T3: one leading bit misaligns the stream
    drive_bit(1'b0);
    send_pattern(24);
    chk("t3_relock", 32'(lock_sig), 32'd1);

    // T5: three violations in one window, one in the next
    do_reset();
    send_pattern(20);
    for (int i = 0; i < 3; i++) begin
      send_badmark();
      send_pattern(4);
    end
    send_pattern(30);
    send_badmark();
    send_pattern(10);
    chk("t5_still_locked", 32'(lock_sig), 32'd1);
    chk("t5_err_cnt", 32'(err_cnt), 32'd4);

    // T6: saturation of the narrow counter
    do_reset();
    send_pattern(20);
    for (int i = 0; i < 5; i++) begin
      send_badmark();
      send_pattern(40);
    end
    chk("t6_sat_err_cnt", 32'(s_err_cnt), 32'd3);
    chk("t6_wide_err_cnt", 32'(err_cnt), 32'd5);
    chk("t6_locked", 32'(lock_sig), 32'd1);

    // Randomized traffic with violations, bit slips and resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 170) send_data(1'($urandom_range(0, 1)));
      else if (r < 184) send_badmark();
      else if (r < 192) send_pair(1'b1, 1'b0);
      else if (r < 199) drive_bit(1'($urandom_range(0, 1)));
      else do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
